aes128_stream_ctrl: RTL and testbench

//  Initiator/sequencer for the aes128 core. Takes 128-bit blocks (data, key, direction) over a valid/ready stream.

---
 rtl/aes128_stream_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_aes128_stream_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_stream_ctrl.sv
// Stream front-end for the aes128 core: accepts one block at a time, reuses the expanded key
// when possible, sequences reset_key/load_data and returns results on a valid/ready stream.
module aes128_stream_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 7
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [127:0] s_data_i,
  input  logic [127:0] s_key_i,
  input  logic         s_enc_i,
  input  logic         s_rekey_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [127:0] m_data_o,
  output logic         m_enc_o,
  output logic         busy_o,
  output logic         err_o,
  output logic         core_reset_key_o,
  output logic         core_load_data_o,
  output logic         core_enc_or_dec_o,
  output logic [127:0] core_plain_text_o,
  output logic [127:0] core_cipher_key_o,
  input  logic         core_key_ready_i,
  input  logic         core_cipher_ready_i,
  input  logic [127:0] core_cipher_text_i
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_KEY_RST  = 3'd1,
    ST_KEY_WAIT = 3'd2,
    ST_LOAD     = 3'd3,
    ST_RUN      = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            key_valid_q, key_valid_d;
  logic [127:0]    data_q, data_d;
  logic [127:0]    key_q, key_d;
  logic            enc_q, enc_d;
  logic            m_valid_q, m_valid_d;
  logic [127:0]    m_data_q, m_data_d;
  logic            m_enc_q, m_enc_d;
  logic            err_q, err_d;
  logic            s_ready_q, s_ready_d;
  logic            busy_q, busy_d;
  logic            rst_key_q, rst_key_d;
  logic            load_q, load_d;
  logic            accept_s;
  logic            out_free_s;

  // Next-state, datapath capture and registered-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_valid_d = key_valid_q;
    data_d      = data_q;
    key_d       = key_q;
    enc_d       = enc_q;
    m_data_d    = m_data_q;
    m_enc_d     = m_enc_q;
    err_d       = err_q;
    accept_s    = s_valid_i & s_ready_q & (state_q == ST_IDLE);
    out_free_s  = ~m_valid_q | m_ready_i;

    if (m_valid_q & m_ready_i) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          data_d = s_data_i;
          key_d  = s_key_i;
          enc_d  = s_enc_i;
          if (!key_valid_q || s_rekey_i || (s_key_i != key_q)) begin
            state_d = ST_KEY_RST;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_KEY_RST: begin
        cnt_d   = '0;
        state_d = ST_KEY_WAIT;
      end
      ST_KEY_WAIT: begin
        if (core_key_ready_i) begin
          key_valid_d = 1'b1;
          state_d     = ST_LOAD;
        end else if (cnt_q == TO_LAST) begin
          err_d       = 1'b1;
          key_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // A finished result waits in the core while the output register is occupied
        if (!out_free_s) begin
          state_d = ST_RUN;
        end else if (core_cipher_ready_i) begin
          m_data_d  = core_cipher_text_i;
          m_enc_d   = enc_q;
          m_valid_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_q == TO_LAST) begin
          err_d       = 1'b1;
          key_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    s_ready_d = (state_d == ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
    rst_key_d = (state_d == ST_KEY_RST);
    load_d    = (state_d == ST_LOAD);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      data_q      <= 128'h0;
      key_q       <= 128'h0;
      enc_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= 128'h0;
      m_enc_q     <= 1'b0;
      err_q       <= 1'b0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      rst_key_q   <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      data_q      <= data_d;
      key_q       <= key_d;
      enc_q       <= enc_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_enc_q     <= m_enc_d;
      err_q       <= err_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      rst_key_q   <= rst_key_d;
      load_q      <= load_d;
    end
  end

  assign s_ready_o         = s_ready_q;
  assign m_valid_o         = m_valid_q;
  assign m_data_o          = m_data_q;
  assign m_enc_o           = m_enc_q;
  assign busy_o            = busy_q;
  assign err_o             = err_q;
  assign core_reset_key_o  = rst_key_q;
  assign core_load_data_o  = load_q;
  assign core_enc_or_dec_o = enc_q;
  assign core_plain_text_o = data_q;
  assign core_cipher_key_o = key_q;

endmodule

// File: tb/tb_aes128_stream_ctrl.sv
// Directed bench for aes128_stream_ctrl using a behavioural stand-in for the aes128 core
// (FIPS-197 vector recognised, simple reversible mapping otherwise).
module tb_aes128_stream_ctrl;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h000000000000000000000000ffffffff;
  localparam logic [127:0] K3 = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
  localparam logic [127:0] D3 = 128'h12345678000000000000000000000000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready_o;
  logic [127:0] s_data = 128'h0;
  logic [127:0] s_key = 128'h0;
  logic         s_enc = 1'b0;
  logic         s_rekey = 1'b0;
  logic         m_valid_o;
  logic         m_ready = 1'b1;
  logic [127:0] m_data_o;
  logic         m_enc_o;
  logic         busy_o;
  logic         err_o;
  logic         core_reset_key_o;
  logic         core_load_data_o;
  logic         core_enc_or_dec_o;
  logic [127:0] core_plain_text_o;
  logic [127:0] core_cipher_key_o;
  logic         key_ready = 1'b0;
  logic         cipher_ready = 1'b0;
  logic [127:0] cipher_text = 128'h0;

  int total = 0;
  int bad   = 0;
  int rk_cnt = 0;
  int mv_cnt = 0;
  int kcnt = 0;
  int ccnt = 0;
  int key_lat = 10;
  int cip_lat = 5;
  bit key_stuck = 1'b0;

  aes128_stream_ctrl #(.TIMEOUT_CYC(64), .TO_W(7)) dut (
    .clk_i(clk), .reset_i(rst),
    .s_valid_i(s_valid), .s_ready_o(s_ready_o), .s_data_i(s_data), .s_key_i(s_key),
    .s_enc_i(s_enc), .s_rekey_i(s_rekey),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready), .m_data_o(m_data_o), .m_enc_o(m_enc_o),
    .busy_o(busy_o), .err_o(err_o),
    .core_reset_key_o(core_reset_key_o), .core_load_data_o(core_load_data_o),
    .core_enc_or_dec_o(core_enc_or_dec_o), .core_plain_text_o(core_plain_text_o),
    .core_cipher_key_o(core_cipher_key_o), .core_key_ready_i(key_ready),
    .core_cipher_ready_i(cipher_ready), .core_cipher_text_i(cipher_text)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] stub_aes(input logic [127:0] d, input logic [127:0] k, input logic e);
    if (k == K1 && e && d == PT) return CT;
    else if (k == K1 && !e && d == CT) return PT;
    else if (e) return d ^ k;
    else return ~(d ^ k);
  endfunction

  // Core stand-in: result is computed from the core inputs as they stand at completion
  always @(posedge clk) begin
    if (rst) begin
      key_ready <= 1'b0; cipher_ready <= 1'b0; kcnt <= 0; ccnt <= 0;
    end else begin
      if (core_reset_key_o) begin key_ready <= 1'b0; kcnt <= key_lat; end
      else if (kcnt > 1) kcnt <= kcnt - 1;
      else if (kcnt == 1) begin kcnt <= 0; key_ready <= !key_stuck; end
      if (core_load_data_o) begin cipher_ready <= 1'b0; ccnt <= cip_lat; end
      else if (ccnt > 1) ccnt <= ccnt - 1;
      else if (ccnt == 1) begin
        ccnt <= 0; cipher_ready <= 1'b1;
        cipher_text <= stub_aes(core_plain_text_o, core_cipher_key_o, core_enc_or_dec_o);
      end
    end
  end

  always @(posedge clk) begin
    if (core_reset_key_o) rk_cnt <= rk_cnt + 1;
    if (m_valid_o) mv_cnt <= mv_cnt + 1;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [127:0] d, input logic [127:0] k, input logic e, input logic r);
    int n = 0;
    while (!s_ready_o && n < 300) begin @(negedge clk); n++; end
    if (!s_ready_o) begin
      total++; bad++;
      $display("FAIL send_wait: s_ready_o still 0 after %0d cycles", n);
    end else begin
      s_data = d; s_key = k; s_enc = e; s_rekey = r; s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0; s_rekey = 1'b0;
    end
  endtask

  task automatic get(input string nm, input logic [127:0] exp_d, input logic exp_e);
    int n = 0;
    while (!m_valid_o && n < 300) begin @(negedge clk); n++; end
    if (!m_valid_o) begin
      total++; bad++;
      $display("FAIL %s_wait: m_valid_o still 0 after %0d cycles", nm, n);
    end else begin
      chk({nm, "_data"}, m_data_o, exp_d);
      chk({nm, "_enc"}, {127'h0, m_enc_o}, {127'h0, exp_e});
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [127:0] data;
    logic [127:0] key;
    logic         enc;
    logic         rekey;
    logic [127:0] exp;
    logic         exp_kexp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int rk0, mv0, n, stable;
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rk0, mv0, n;
    bit stable;
    vecs[0] = '{PT, K1, 1'b1, 1'b0, CT, 1'b1};
    vecs[1] = '{CT, K1, 1'b0, 1'b0, PT, 1'b0};
    vecs[2] = '{PT, K1, 1'b1, 1'b1, CT, 1'b1};
    vecs[3] = '{D3, K2, 1'b1, 1'b0, 128'h123456780000000000000000ffffffff, 1'b1};
    vecs[4] = '{D3, K2, 1'b0, 1'b0, 128'hedcba987ffffffffffffffff00000000, 1'b0};
    vecs[5] = '{PT, K1, 1'b1, 1'b0, CT, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_s_ready", {127'h0, s_ready_o}, 128'h0);
    chk("rst_m_valid", {127'h0, m_valid_o}, 128'h0);
    chk("rst_busy_err", {126'h0, busy_o, err_o}, 128'h0);
    chk("rst_core_ctl", {125'h0, core_reset_key_o, core_load_data_o, core_enc_or_dec_o}, 128'h0);
    chk("rst_core_pt", core_plain_text_o, 128'h0);
    chk("rst_m_data", m_data_o, 128'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      rk0 = rk_cnt;
      send(vecs[i].data, vecs[i].key, vecs[i].enc, vecs[i].rekey);
      chk($sformatf("v%0d_keyrst_now", i), {127'h0, core_reset_key_o}, {127'h0, vecs[i].exp_kexp});
      chk($sformatf("v%0d_load_now", i), {127'h0, core_load_data_o}, {127'h0, ~vecs[i].exp_kexp});
      get($sformatf("v%0d", i), vecs[i].exp, vecs[i].enc);
      chk($sformatf("v%0d_keyrst_pulses", i), 128'(rk_cnt - rk0), {127'h0, vecs[i].exp_kexp});
    end

    // Output back-pressure: result A held, result B parked in the core until A is taken
    m_ready = 1'b0;
    send(PT, K1, 1'b1, 1'b0);
    n = 0;
    while (!m_valid_o && n < 300) begin @(negedge clk); n++; end
    chk("bp_a_data", m_data_o, CT);
    send(CT, K1, 1'b0, 1'b0);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (m_data_o !== CT || m_valid_o !== 1'b1 || m_enc_o !== 1'b1) stable = 1'b0;
    end
    chk("bp_a_stable", {127'h0, stable}, 128'h1);
    chk("bp_b_pending", {126'h0, busy_o, s_ready_o}, 128'h2);
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_b_valid", {127'h0, m_valid_o}, 128'h1);
    chk("bp_b_data", m_data_o, PT);
    chk("bp_b_enc", {127'h0, m_enc_o}, 128'h0);
    @(negedge clk);
    chk("bp_drained", {127'h0, m_valid_o}, 128'h0);

    // Key expansion never completes: timeout after 64 cycles in KEY_WAIT
    key_stuck = 1'b1;
    mv0 = mv_cnt;
    send(PT, K3, 1'b1, 1'b0);
    n = 0;
    while (!err_o && n < 200) begin @(negedge clk); n++; end
    chk("to_cycles", 128'(n), 128'd65);
    chk("to_err_sready", {126'h0, err_o, s_ready_o}, 128'h3);
    chk("to_busy", {127'h0, busy_o}, 128'h0);
    chk("to_no_result", 128'(mv_cnt - mv0), 128'h0);
    key_stuck = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_err_sticky", {127'h0, err_o}, 128'h1);

    // Reset in the middle of RUN, then a clean block re-expands the key
    cip_lat = 40;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_clears_err", {127'h0, err_o}, 128'h0);
    send(PT, K1, 1'b1, 1'b0);
    n = 0;
    while (!core_load_data_o && n < 100) begin @(negedge clk); n++; end
    chk("mid_reached_load", {127'h0, core_load_data_o}, 128'h1);
    repeat (3) @(negedge clk);
    chk("mid_busy_before", {127'h0, busy_o}, 128'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy_mvalid", {126'h0, busy_o, m_valid_o}, 128'h0);
    rst = 1'b0;
    cip_lat = 5;
    @(negedge clk);
    rk0 = rk_cnt;
    send(PT, K1, 1'b1, 1'b0);
    chk("post_rst_keyrst_now", {127'h0, core_reset_key_o}, 128'h1);
    get("post_rst", CT, 1'b1);
    chk("post_rst_pulses", 128'(rk_cnt - rk0), 128'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
